// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing from a 100 MHz clock (divide-by-4 pixel rate), plus a map-window decode.
// Outputs are registered from next-state counters so they line up exactly with pixel_x/pixel_y.
module vga_sync_gen #(
    parameter int MAP_WIDTH_X = 100,
    parameter int MAP_WIDTH_Y = 100,
    parameter int MAP_X0      = 270,
    parameter int MAP_Y0      = 190,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       map_on,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] H_SYNC_LO = 10'd656;
    localparam logic [9:0] H_SYNC_HI = 10'd751;
    localparam logic [9:0] H_LAST    = 10'd799;
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] MX_LO     = 10'(MAP_X0);
    localparam logic [9:0] MX_HI     = 10'(MAP_X0 + MAP_WIDTH_X - 1);
    localparam logic [9:0] MY_LO     = 10'(MAP_Y0);
    localparam logic [9:0] MY_HI     = 10'(MAP_Y0 + MAP_WIDTH_Y - 1);

    logic [1:0] div_q;
    logic [9:0] h_q, v_q, h_d, v_d;
    logic       hsync_q, vsync_q, video_on_q, map_on_q, frame_start_q;
    logic       hsync_d, vsync_d, video_on_d, map_on_d;
    logic [9:0] map_x_q, map_y_q, map_x_d, map_y_d;
    logic       tick, wrap;

    assign tick = (div_q == 2'd3);
    assign wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Decode the position the counters are about to take, so flags and counters move together.
        hsync_d    = !((h_d >= H_SYNC_LO) && (h_d <= H_SYNC_HI));
        vsync_d    = !((v_d >= V_SYNC_LO) && (v_d <= V_SYNC_HI));
        video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
        map_on_d   = video_on_d && (h_d >= MX_LO) && (h_d <= MX_HI)
                                && (v_d >= MY_LO) && (v_d <= MY_HI);
        map_x_d    = map_on_d ? (h_d - MX_LO) : '0;
        map_y_d    = map_on_d ? (v_d - MY_LO) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            map_on_q      <= 1'b0;
            map_x_q       <= '0;
            map_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_q + 2'd1;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= wrap;
            // Flags only move on a pixel tick, so they hold for all 4 clk of a pixel.
            if (tick) begin
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
                video_on_q <= video_on_d;
                map_on_q   <= map_on_d;
                map_x_q    <= map_x_d;
                map_y_q    <= map_y_d;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign map_on      = map_on_q;
    assign map_x       = map_x_q;
    assign map_y       = map_y_q;
    assign pixel_tick  = tick;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: expected outputs derived from the clock count since reset.
module tb_vga_sync_gen;

    localparam int HT   = 800;
    localparam int VVIS = 6;
    localparam int VFP  = 1;
    localparam int VSL  = 2;
    localparam int VBP  = 2;
    localparam int VT   = VVIS + VFP + VSL + VBP;
    localparam int VS0  = VVIS + VFP;
    localparam int MX0  = 270;
    localparam int MW   = 100;
    localparam int MY0  = 2;
    localparam int MH   = 3;
    localparam int FRAME_CLK = 4 * HT * VT;

    typedef struct packed {
        logic       tick;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       von;
        logic       mon;
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] mx;
        logic [9:0] my;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync, vsync, video_on, map_on, pixel_tick, frame_start;
    logic [9:0] pixel_x, pixel_y, map_x, map_y;
    obs_t       act;

    int tests = 0;
    int fails = 0;
    int n = 0;

    vga_sync_gen #(
        .MAP_WIDTH_X(MW), .MAP_WIDTH_Y(MH), .MAP_X0(MX0), .MAP_Y0(MY0),
        .V_VISIBLE(VVIS), .V_FRONT(VFP), .V_SYNC(VSL), .V_BACK(VBP)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .map_on(map_on), .map_x(map_x),
        .map_y(map_y), .pixel_tick(pixel_tick), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign act = {pixel_tick, frame_start, hsync, vsync, video_on, map_on,
                  pixel_x, pixel_y, map_x, map_y};

    // n = clk edges since the last edge that saw reset; the screen position is ticks = n/4.
    function automatic obs_t model(input int cnt);
        obs_t e;
        int   ticks, pos, h, v;
        ticks  = cnt / 4;
        pos    = ticks % (HT * VT);
        h      = pos % HT;
        v      = pos / HT;
        e      = '0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.tick = (cnt % 4 == 3);
        e.fs   = (ticks > 0) && (pos == 0) && (cnt % 4 == 0);
        if (ticks > 0) begin
            e.px  = 10'(h);
            e.py  = 10'(v);
            e.hs  = !(h >= 656 && h <= 751);
            e.vs  = !(v >= VS0 && v < VS0 + VSL);
            e.von = (h < 640) && (v < VVIS);
            e.mon = e.von && (h >= MX0) && (h < MX0 + MW) && (v >= MY0) && (v < MY0 + MH);
            e.mx  = e.mon ? 10'(h - MX0) : 10'd0;
            e.my  = e.mon ? 10'(v - MY0) : 10'd0;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) n = 0;
        else     n = n + 1;
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        repeat (3) begin
            step();
            e = model(0);
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL reset_state n=%0d got=%h want=%h", n, act, e);
            end
        end
    endtask

    task automatic test_first_tick();
        obs_t e;
        int   ticks = 0;
        rst = 1'b0;
        repeat (4) begin
            step();
            e = model(n);
            if (pixel_tick) ticks++;
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL first_tick_cycle n=%0d got=%h want=%h", n, act, e);
            end
        end
        tests++;
        if (ticks !== 1 || pixel_x !== 10'd1 || pixel_y !== 10'd0 || video_on !== 1'b1) begin
            fails++;
            $display("FAIL first_tick ticks=%0d x=%0d y=%0d von=%b want 1,1,0,1",
                     ticks, pixel_x, pixel_y, video_on);
        end
    endtask

    task automatic test_line();
        obs_t e;
        int   low = 0, fall_n = -1, fall_px = -1;
        logic prev = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        while (n < 4 * HT + 4) begin
            step();
            e = model(n);
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL line_cycle n=%0d got=%h want=%h", n, act, e);
            end
            if (!hsync) low++;
            if (!hsync && prev) begin
                fall_n  = n;
                fall_px = int'(pixel_x);
            end
            prev = hsync;
        end
        tests++;
        if (low !== 384) begin
            fails++;
            $display("FAIL hsync_low_clk got=%0d want=384", low);
        end
        tests++;
        if (fall_px !== 656 || fall_n !== 4 * 656) begin
            fails++;
            $display("FAIL hsync_fall px=%0d n=%0d want 656,%0d", fall_px, fall_n, 4 * 656);
        end
        tests++;
        if (pixel_x !== 10'd1 || pixel_y !== 10'd1) begin
            fails++;
            $display("FAIL line_period x=%0d y=%0d want 1,1", pixel_x, pixel_y);
        end
    endtask

    task automatic test_frame();
        obs_t e;
        int   vlow = 0, vfall_py = -1, von_ticks = 0, fs_cnt = 0, fs_n = -1, pos, h, v;
        logic prev = 1'b1;
        int   pt_h [4] = '{270, 369, 370, 269};
        int   pt_v [4] = '{MY0, MY0 + MH - 1, MY0 + MH - 1, MY0};
        logic pt_on[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int   pt_mx[4] = '{0, 99, 0, 0};
        int   pt_my[4] = '{0, MH - 1, 0, 0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        while (n < FRAME_CLK + 4) begin
            step();
            e = model(n);
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL frame_cycle n=%0d got=%h want=%h", n, act, e);
            end
            if (!vsync) vlow++;
            if (!vsync && prev) vfall_py = int'(pixel_y);
            prev = vsync;
            if (video_on && pixel_tick) von_ticks++;
            if (frame_start) begin
                fs_cnt++;
                fs_n = n;
            end
            pos = (n / 4) % (HT * VT);
            h   = pos % HT;
            v   = pos / HT;
            for (int k = 0; k < 4; k++) begin
                if (n % 4 == 0 && n > 0 && h == pt_h[k] && v == pt_v[k]) begin
                    tests++;
                    if (map_on !== pt_on[k] || map_x !== 10'(pt_mx[k]) || map_y !== 10'(pt_my[k])) begin
                        fails++;
                        $display("FAIL map_point(%0d,%0d) on=%b x=%0d y=%0d want %b,%0d,%0d",
                                 h, v, map_on, map_x, map_y, pt_on[k], pt_mx[k], pt_my[k]);
                    end
                end
            end
        end
        tests++;
        if (vlow !== 4 * HT * VSL || vfall_py !== VS0) begin
            fails++;
            $display("FAIL vsync_low clk=%0d py=%0d want %0d,%0d", vlow, vfall_py, 4 * HT * VSL, VS0);
        end
        tests++;
        if (von_ticks !== 640 * VVIS) begin
            fails++;
            $display("FAIL video_on_ticks got=%0d want=%0d", von_ticks, 640 * VVIS);
        end
        tests++;
        if (fs_cnt !== 1 || fs_n !== FRAME_CLK) begin
            fails++;
            $display("FAIL frame_start cnt=%0d n=%0d want 1,%0d", fs_cnt, fs_n, FRAME_CLK);
        end
        tests++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || pixel_x !== 10'd1 || pixel_y !== 10'd0) begin
            fails++;
            $display("FAIL wrap hs=%b vs=%b x=%0d y=%0d want 1,1,1,0", hsync, vsync, pixel_x, pixel_y);
        end
    endtask

    // First pass lands on (500,1) with divider=2; later passes use random points and lengths.
    task automatic test_mid_reset();
        obs_t e;
        int   target, len;
        for (int it = 0; it < 6; it++) begin
            target = (it == 0) ? n + (4 * ((FRAME_CLK / 4 - (n / 4)) % (HT * VT) + HT + 500) + 2 - (n % 4))
                               : n + int'($urandom_range(50, 2000));
            len    = (it == 0) ? 1 : int'($urandom_range(1, 3));
            while (n < target) begin
                step();
                e = model(n);
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL pre_reset n=%0d got=%h want=%h", n, act, e);
                end
            end
            if (it == 0) begin
                tests++;
                if (pixel_x !== 10'd500 || pixel_y !== 10'd1 || n % 4 != 2) begin
                    fails++;
                    $display("FAIL reset_point x=%0d y=%0d phase=%0d want 500,1,2", pixel_x, pixel_y, n % 4);
                end
            end
            rst = 1'b1;
            repeat (len) begin
                step();
                e = model(0);
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL mid_reset it=%0d got=%h want=%h", it, act, e);
                end
            end
            rst = 1'b0;
            repeat (4) begin
                step();
                e = model(n);
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL restart it=%0d n=%0d got=%h want=%h", it, n, act, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter MAP_WIDTH_X, default 100: width in pixels of the map window.
REQ-003 Parameter MAP_WIDTH_Y, default 100: height in pixels of the map window.
REQ-004 Parameter MAP_X0, default 270: screen column of the map window's left edge.
REQ-005 Parameter MAP_Y0, default 190: screen row of the map window's top edge.
REQ-006 Port clk, input, 1: 100 MHz system clock.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port hsync, output, 1: horizontal sync, active-low.
REQ-009 Port vsync, output, 1: vertical sync, active-low.
REQ-010 Port video_on, output, 1: high inside the 640x480 visible area.
REQ-011 Port pixel_x, output, 10: current screen column (h_count).
REQ-012 Port pixel_y, output, 10: current screen row (v_count).
REQ-013 Port map_on, output, 1: high inside the map window; drives the map renderer's map_on.
REQ-014 Port map_x, output, 10: column relative to MAP_X0; drives the map renderer's x.
REQ-015 Port map_y, output, 10: row relative to MAP_Y0; drives the map renderer's y.
REQ-016 Port pixel_tick, output, 1: one-clk pulse at the 25 MHz pixel rate.
REQ-017 Port frame_start, output, 1: one-clk pulse when the counters wrap to (0,0).

Function
REQ-018 A 2-bit divider SHALL count 0..3 and wrap; pixel_tick SHALL be high in the cycle where the divider equals 3.
REQ-019 h_count SHALL advance only on pixel_tick, counting 0..799, then wrapping to 0.
REQ-020 v_count SHALL increment only on a pixel_tick where h_count = 799, counting 0..524, then wrapping to 0.
REQ-021 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-022 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-023 hsync SHALL be 0 exactly when h_count is 656..751; vsync SHALL be 0 exactly when v_count is 490..491.
REQ-024 video_on SHALL equal (h_count < 640) AND (v_count < 480).
REQ-025 map_on SHALL equal video_on AND h_count in [MAP_X0, MAP_X0+MAP_WIDTH_X-1] AND v_count in [MAP_Y0, MAP_Y0+MAP_WIDTH_Y-1].
REQ-026 map_x and map_y SHALL equal h_count-MAP_X0 and v_count-MAP_Y0 while map_on = 1, and SHALL be 0 otherwise, so the downstream index never exceeds MAP_WIDTH_X*MAP_WIDTH_Y-1.
REQ-027 All outputs except pixel_tick SHALL be registered, computed from next-state counter values, and SHALL update on the same edge as the counters, with zero lag relative to pixel_x/pixel_y.
REQ-028 frame_start SHALL be high for exactly one clk, on the edge where h_count and v_count both become 0 via wrap.
REQ-029 Between pixel ticks, all outputs SHALL hold their values for 4 clk.

Reset
REQ-030 While rst = 1 at a clk edge: divider=0, h_count=0, v_count=0, hsync=1, vsync=1, video_on=0, map_on=0, map_x=0, map_y=0, frame_start=0, pixel_tick=0.
REQ-031 Reset asserted mid-frame SHALL take effect on the next clk edge regardless of divider phase.
REQ-032 The first pixel_tick SHALL occur 4 clk after rst deasserts, advancing to h_count=1; frame_start SHALL not pulse on reset exit.

Verification
REQ-033 Release reset, run 4 clk -> pixel_tick pulses once on the 4th clk; pixel_x=1, pixel_y=0, video_on=1.
REQ-034 Run one line -> hsync low for exactly 96 ticks (384 clk), falling when pixel_x becomes 656; line period is 3200 clk.
REQ-035 Run one full frame -> vsync low for 2 lines, at pixel_y 490..491; frame_start period is 1,680,000 clk; video_on is high for exactly 307,200 ticks.
REQ-036 At (270,190), map_on=1 and map_x=map_y=0; at (369,289), map_x=map_y=99; at (370,289) and at (269,190), map_on=0 and map_x=map_y=0.
REQ-037 Assert rst for 1 clk at pixel (500,300) with divider=2 -> next edge all outputs equal REQ-030 values; counting restarts per REQ-032.
REQ-038 Wrap check: a tick at (799,524) -> (0,0), frame_start=1 for one clk, vsync=1, hsync=1.
